param_alu: RTL and testbench
============================

PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 4..64).
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, operation request.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 SHALL have port command, input, 4, opcode: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MUL, 9-15 illegal.
REQ-007 SHALL have ports operandA, operandB, input, WIDTH, operands.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port result, output, WIDTH, operation result.
REQ-011 SHALL have ports carryout, zero, overflow, error, output, 1 each, status flags.

Function
REQ-012 SHALL accept a request only on a cycle with in_valid && in_ready; command and operands are captured internally at that edge, and later input changes have no effect.
REQ-013 SHALL use three states: IDLE (in_ready=1), MUL (iterating), HOLD (out_valid=1). in_ready SHALL be 1 only in IDLE.
REQ-014 SHALL, for opcodes 0-7 and 9-15 accepted at edge N, enter HOLD with out_valid=1 after edge N (latency 1).
REQ-015 SHALL hold result and flags stable in HOLD until out_ready=1, then return to IDLE on that edge. A new request is accepted no earlier than the following cycle.
REQ-016 SHALL compute ADD/SUB modulo 2^WIDTH. carryout is the carry out of bit WIDTH-1, and for SUB is computed as A + ~B + 1. overflow is the two's-complement signed overflow.
REQ-017 SHALL set zero=1 when the ADD/SUB result is all zeros.
REQ-018 SHALL force carryout, overflow and zero to 0 for every opcode other than ADD/SUB.
REQ-019 SHALL produce, for SLT, result = {WIDTH-1 zeros, (signed A < signed B)}. The comparison SHALL be correct when A and B have opposite signs and when the subtraction overflows.
REQ-020 SHALL compute AND/NAND/NOR/OR/XOR bitwise over WIDTH.
REQ-021 SHALL, for illegal opcodes, return result=0 and error=1 with latency 1. error SHALL be 0 for all legal opcodes.
REQ-022 SHALL compute MUL (when enabled) by shift-add, one multiplier bit per cycle. It SHALL enter MUL on accept, stay in MUL for exactly WIDTH cycles, and set out_valid at edge N+WIDTH. result is the low WIDTH bits of the unsigned product.
REQ-023 SHALL hold in_valid-independent behaviour during MUL: requests are not accepted, and in_valid is ignored.
REQ-024 SHALL, on a rst_n assertion mid-MUL or mid-HOLD, abort the operation and discard its result. No out_valid SHALL follow.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, result=0, and carryout=zero=overflow=error=0.
REQ-026 SHALL, after deassertion, accept a request on the first rising edge where in_valid=1.

Configuration
REQ-027 SHALL compile the MUL datapath and MUL state only when macro PARAM_ALU_MUL_EN is defined.
REQ-028 SHALL, without PARAM_ALU_MUL_EN, treat opcode 8 as illegal per REQ-021 and never enter the MUL state.

Verification (WIDTH=8 unless noted)
REQ-029 SHALL cover: ADD 0x7F+0x01 accepted at edge N -> out_valid at N+1, result 0x80, overflow=1, carryout=0, zero=0.
REQ-030 SHALL cover: SUB 0x05-0x05 -> result 0x00, zero=1, carryout=1, overflow=0. SUB 0x00-0x01 -> 0xFF, carryout=0.
REQ-031 SHALL cover: SLT A=0x80, B=0x7F -> result 0x01. SLT A=0x7F, B=0x80 -> 0x00. Both cases have all flags 0.
REQ-032 SHALL cover (with PARAM_ALU_MUL_EN): MUL 0x0D*0x0B -> out_valid exactly 8 cycles after accept, result 0x8F, and in_ready=0 throughout. Without the macro: result 0x00, error=1 at N+1.
REQ-033 SHALL cover backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags unchanged, in_ready=0. Then raise out_ready -> IDLE on the next edge.
REQ-034 SHALL cover reset: assert rst_n=0 at cycle 3 of a MUL -> out_valid stays 0 immediately and after release, and in_ready=1.

Source files
------------

// File: rtl/param_alu.sv
// Handshaked ALU: single-cycle logic/arith ops, optional shift-add multiplier.
// Optional feature: define PARAM_ALU_MUL_EN to build the MUL opcode (8) datapath and state.
module param_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow,
    output logic             error
);

`ifdef PARAM_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

    state_t state;

    logic             is_sub;
    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] comb_res;
    logic             comb_c, comb_z, comb_v, comb_e;

    assign in_ready = (state == IDLE);

    // SUB is A + ~B + 1 so the carry out has borrow-inverted meaning
    always_comb begin
        is_sub   = (command == 4'd1);
        bop      = is_sub ? ~operandB : operandB;
        sum      = {1'b0, operandA} + {1'b0, bop} + (WIDTH+1)'(is_sub);
        comb_res = '0;
        comb_c   = 1'b0;
        comb_z   = 1'b0;
        comb_v   = 1'b0;
        comb_e   = 1'b0;
        case (command)
            4'd0, 4'd1: begin
                comb_res = sum[WIDTH-1:0];
                comb_c   = sum[WIDTH];
                comb_z   = (sum[WIDTH-1:0] == '0);
                comb_v   = (operandA[WIDTH-1] == bop[WIDTH-1]) &&
                           (sum[WIDTH-1] != operandA[WIDTH-1]);
            end
            4'd2: comb_res = operandA ^ operandB;
            4'd3: comb_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            4'd4: comb_res = operandA & operandB;
            4'd5: comb_res = ~(operandA & operandB);
            4'd6: comb_res = ~(operandA | operandB);
            4'd7: comb_res = operandA | operandB;
`ifdef PARAM_ALU_MUL_EN
            4'd8: comb_res = '0;
`endif
            default: comb_e = 1'b1;
        endcase
    end

`ifdef PARAM_ALU_MUL_EN
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carryout  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            error     <= 1'b0;
`ifdef PARAM_ALU_MUL_EN
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        result    <= comb_res;
                        carryout  <= comb_c;
                        zero      <= comb_z;
                        overflow  <= comb_v;
                        error     <= comb_e;
`ifdef PARAM_ALU_MUL_EN
                        // later assignments override the single-cycle path for MUL
                        if (command == 4'd8) begin
                            state     <= MUL;
                            out_valid <= 1'b0;
                            acc       <= '0;
                            mcand     <= operandA;
                            mplier    <= operandB;
                            cnt       <= '0;
                        end
`endif
                    end
                end
`ifdef PARAM_ALU_MUL_EN
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        result    <= acc_next;
                        carryout  <= 1'b0;
                        zero      <= 1'b0;
                        overflow  <= 1'b0;
                        error     <= 1'b0;
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu.sv
// Scoreboard bench for param_alu at WIDTH=8; honours PARAM_ALU_MUL_EN like the design.
module tb_param_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   command;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carryout, zero, overflow, error;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
        logic         e;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    param_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .command  (command),
        .operandA (operandA),
        .operandB (operandB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carryout (carryout),
        .zero     (zero),
        .overflow (overflow),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        m;
        logic [W:0]  s;
        int          sa, sb_i;
        m = '0;
        case (cmd)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                m.res = s[W-1:0];
                m.c = s[W];
                m.z = (m.res == 0);
                m.v = (a[W-1] == b[W-1]) && (m.res[W-1] != a[W-1]);
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                m.res = s[W-1:0];
                m.c = s[W];
                m.z = (m.res == 0);
                m.v = (a[W-1] != b[W-1]) && (m.res[W-1] != a[W-1]);
            end
            4'd2: m.res = a ^ b;
            4'd3: begin
                sa   = a[W-1] ? int'(a) - (1 << W) : int'(a);
                sb_i = b[W-1] ? int'(b) - (1 << W) : int'(b);
                m.res = (sa < sb_i) ? 1 : 0;
            end
            4'd4: m.res = a & b;
            4'd5: m.res = ~(a & b);
            4'd6: m.res = ~(a | b);
            4'd7: m.res = a | b;
`ifdef PARAM_ALU_MUL_EN
            4'd8: m.res = W'(int'(a) * int'(b));
`endif
            default: m.e = 1'b1;
        endcase
        return m;
    endfunction

    function automatic int exp_latency(input logic [3:0] cmd);
`ifdef PARAM_ALU_MUL_EN
        if (cmd == 4'd8) return W;
`endif
        return 1;
    endfunction

    function automatic logic [63:0] observed();
        exp_t o;
        o.res = result;
        o.c = carryout;
        o.z = zero;
        o.v = overflow;
        o.e = error;
        return 64'(o);
    endfunction

    // Called at #1 after a rising edge; returns at the same phase.
    task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold_cycles);
        int   n;
        int   lat;
        logic busy_ok;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        out_ready = (hold_cycles == 0);
        command   = cmd;
        operandA  = a;
        operandB  = b;
        in_valid  = 1'b1;
        sb.push_back(model(cmd, a, b));
        @(posedge clk); #1;
        command  = 4'($urandom);
        operandA = W'($urandom);
        operandB = W'($urandom);
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("busy_in_ready", busy_ok, 1);
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        check("latency", lat, exp_latency(cmd));
        check("hold_in_ready", in_ready, 0);
        e = sb.pop_front();
        check("payload", observed(), 64'(e));
        for (int unsigned i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            check("bp_handshake", {out_valid, in_ready}, 2'b10);
            check("bp_payload", observed(), 64'(e));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic saw_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        command   = '0;
        operandA  = '0;
        operandB  = '0;
        #1;
        check("reset_state", {in_ready, out_valid, observed()}, {1'b1, 1'b0, 64'd0});
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        send(4'd0, 8'h7F, 8'h01, 0);
        send(4'd1, 8'h05, 8'h05, 0);
        send(4'd1, 8'h00, 8'h01, 0);
        send(4'd3, 8'h80, 8'h7F, 0);
        send(4'd3, 8'h7F, 8'h80, 0);
        send(4'd8, 8'h0D, 8'h0B, 0);
        send(4'd12, 8'h33, 8'h44, 0);
        send(4'd0, 8'hFF, 8'h01, 5);
        for (int unsigned i = 0; i < 30; i++)
            send(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), int'($urandom_range(0, 2)));

        // Abort an in-flight op at its third busy cycle
        out_ready = 1'b0;
        command   = 4'd8;
        operandA  = 8'h0D;
        operandB  = 8'h0B;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_reset", {in_ready, out_valid, observed()}, {1'b1, 1'b0, 64'd0});
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int unsigned i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_valid", {saw_valid, in_ready}, 2'b01);
        send(4'd0, 8'h10, 8'h20, 0);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
